// File: rtl/counter_nb.sv
`default_nettype none
// ============================================================================
//  Module   : counter_nb
//  Brief    : Parametrised multi-mode counter (up, down, down-by-step, load)
//             with cascade carry, registered compare-match pulse and a
//             saturating wrap-event counter.
//  Revision : 1.0  initial release
// ============================================================================
module counter_nb #(
    parameter int WIDTH   = 8,
    parameter int STEP_DN = 3,
    parameter int WRAP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              carry_in,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  D,
    input  logic [WIDTH-1:0]  cmp_val,
    output logic [WIDTH-1:0]  Q,
    output logic              rco,
    output logic              load,
    output logic              carry_out,
    output logic              match,
    output logic [WRAP_W-1:0] wraps
);

    localparam logic [1:0]        c_MODE_UP   = 2'b00;
    localparam logic [1:0]        c_MODE_DN1  = 2'b01;
    localparam logic [1:0]        c_MODE_DNS  = 2'b10;
    localparam logic [1:0]        c_MODE_LOAD = 2'b11;
    localparam logic [WIDTH:0]    c_ONE_EXT   = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]    c_STEP_EXT  = (WIDTH+1)'(STEP_DN);
    localparam logic [WRAP_W-1:0] c_WRAP_MAX  = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] c_WRAP_ONE  = WRAP_W'(1);

    logic [WIDTH-1:0]  r_q;
    logic              r_rco;
    logic              r_load;
    logic              r_match;
    logic [WRAP_W-1:0] r_wraps;

    logic              w_act;
    logic [WIDTH:0]    w_q_ext;
    logic [WIDTH:0]    w_up_ext;
    logic [WIDTH:0]    w_dn1_ext;
    logic [WIDTH:0]    w_dns_ext;
    logic [WIDTH-1:0]  w_q_next;
    logic              w_terminal;
    logic              w_is_load;

    // The counter only advances when both the local enable and the
    // cascade enable from the lower stage are present.
    assign w_act     = enable & carry_in;

    // All arithmetic is done one bit wider so the top bit is the carry
    // (up) or the borrow (down) of the WIDTH-bit operation.
    assign w_q_ext   = {1'b0, r_q};
    assign w_up_ext  = w_q_ext + c_ONE_EXT;
    assign w_dn1_ext = w_q_ext - c_ONE_EXT;
    assign w_dns_ext = w_q_ext - c_STEP_EXT;

    // Select the candidate next count and the terminal (wrap/borrow) flag.
    always_comb begin
        w_q_next   = r_q;
        w_terminal = 1'b0;
        w_is_load  = 1'b0;
        case (mode)
            c_MODE_UP: begin
                w_q_next   = w_up_ext[WIDTH-1:0];
                w_terminal = w_up_ext[WIDTH];
            end
            c_MODE_DN1: begin
                w_q_next   = w_dn1_ext[WIDTH-1:0];
                w_terminal = w_dn1_ext[WIDTH];
            end
            c_MODE_DNS: begin
                w_q_next   = w_dns_ext[WIDTH-1:0];
                w_terminal = w_dns_ext[WIDTH];
            end
            c_MODE_LOAD: begin
                w_q_next   = D;
                w_terminal = 1'b0;
                w_is_load  = 1'b1;
            end
            default: begin
                w_q_next   = r_q;
                w_terminal = 1'b0;
                w_is_load  = 1'b0;
            end
        endcase
    end

    // Cascade carry is combinational so the upper stage sees it in the
    // same cycle; it equals the rco value this stage will register.
    assign carry_out = w_act & w_terminal;

    // Count register with its registered status flags; the flags are
    // single-cycle pulses that drop whenever the counter is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            r_rco   <= 1'b0;
            r_load  <= 1'b0;
            r_match <= 1'b0;
        end else if (w_act) begin
            r_q     <= w_q_next;
            r_rco   <= w_terminal;
            r_load  <= w_is_load;
            r_match <= (w_q_next == cmp_val);
        end else begin
            r_rco   <= 1'b0;
            r_load  <= 1'b0;
            r_match <= 1'b0;
        end
    end

    // Saturating wrap-event counter; stops at all-ones, only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wraps <= '0;
        end else if (w_act && w_terminal && (r_wraps != c_WRAP_MAX)) begin
            r_wraps <= r_wraps + c_WRAP_ONE;
        end
    end

    assign Q     = r_q;
    assign rco   = r_rco;
    assign load  = r_load;
    assign match = r_match;
    assign wraps = r_wraps;

endmodule
`default_nettype wire

// File: tb/tb_counter_nb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_nb
//  Brief    : Directed self-checking bench for counter_nb (WIDTH=4) plus a
//             two-stage cascade.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_nb;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       carry_in;
    logic [1:0] mode;
    logic [3:0] D;
    logic [3:0] cmp_val;
    logic [3:0] Q;
    logic       rco;
    logic       load;
    logic       carry_out;
    logic       match;
    logic [3:0] wraps;

    logic       reset_c;
    logic       chain_en;
    logic [3:0] ql, qh;
    logic       rco_l, rco_h, load_l, load_h, co_l, co_h, m_l, m_h;
    logic [3:0] wr_l, wr_h;

    int n_cmp;
    int n_err;

    counter_nb #(.WIDTH(4), .STEP_DN(3), .WRAP_W(4)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .carry_in(carry_in),
        .mode(mode), .D(D), .cmp_val(cmp_val), .Q(Q), .rco(rco),
        .load(load), .carry_out(carry_out), .match(match), .wraps(wraps)
    );

    counter_nb #(.WIDTH(4), .STEP_DN(3), .WRAP_W(4)) u_lo (
        .clk(clk), .reset(reset_c), .enable(chain_en), .carry_in(1'b1),
        .mode(2'b00), .D(4'h0), .cmp_val(4'h0), .Q(ql), .rco(rco_l),
        .load(load_l), .carry_out(co_l), .match(m_l), .wraps(wr_l)
    );

    counter_nb #(.WIDTH(4), .STEP_DN(3), .WRAP_W(4)) u_hi (
        .clk(clk), .reset(reset_c), .enable(chain_en), .carry_in(co_l),
        .mode(2'b00), .D(4'h0), .cmp_val(4'h0), .Q(qh), .rco(rco_h),
        .load(load_h), .carry_out(co_h), .match(m_h), .wraps(wr_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int pulses;
        int pulse_at;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        carry_in = 1'b1;
        mode     = 2'b00;
        D        = 4'h0;
        cmp_val  = 4'h5;
        reset_c  = 1'b1;
        chain_en = 1'b0;

        // Reset held for 6 cycles
        repeat (6) tick();
        check("rst_Q", 32'(Q), 32'h0);
        check("rst_rco", 32'(rco), 32'h0);
        check("rst_load", 32'(load), 32'h0);
        check("rst_match", 32'(match), 32'h0);
        check("rst_wraps", 32'(wraps), 32'h0);
        check("rst_carry_out", 32'(carry_out), 32'h0);

        // Count up 18 edges: 1..15,0,1,2
        reset  = 1'b0;
        enable = 1'b1;
        mode   = 2'b00;
        for (int i = 1; i <= 18; i++) begin
            check("up_carry_out", 32'(carry_out), 32'(((i - 1) % 16) == 15));
            tick();
            check("up_Q", 32'(Q), 32'(i % 16));
            check("up_rco", 32'(rco), 32'(i == 16));
            check("up_match", 32'(match), 32'((i % 16) == 5));
        end
        check("up_wraps", 32'(wraps), 32'h1);

        // Load A, then step down by 3: 7,4,1,E
        mode = 2'b11;
        D    = 4'hA;
        tick();
        check("ld_Q", 32'(Q), 32'hA);
        check("ld_load", 32'(load), 32'h1);
        check("ld_rco", 32'(rco), 32'h0);
        mode = 2'b10;
        tick();
        check("dns_Q7", 32'(Q), 32'h7);
        check("dns_load", 32'(load), 32'h0);
        check("dns_rco7", 32'(rco), 32'h0);
        tick();
        check("dns_Q4", 32'(Q), 32'h4);
        check("dns_rco4", 32'(rco), 32'h0);
        tick();
        check("dns_Q1", 32'(Q), 32'h1);
        check("dns_rco1", 32'(rco), 32'h0);
        check("dns_carry_out", 32'(carry_out), 32'h1);
        tick();
        check("dns_QE", 32'(Q), 32'hE);
        check("dns_rcoE", 32'(rco), 32'h1);
        check("dns_loadE", 32'(load), 32'h0);
        check("dns_wraps", 32'(wraps), 32'h2);

        // Load 0, then down by 1: F with borrow, then E
        mode = 2'b11;
        D    = 4'h0;
        tick();
        check("ld0_Q", 32'(Q), 32'h0);
        mode = 2'b01;
        #1;
        check("dn1_carry_out0", 32'(carry_out), 32'h1);
        tick();
        check("dn1_QF", 32'(Q), 32'hF);
        check("dn1_rcoF", 32'(rco), 32'h1);
        check("dn1_carry_outF", 32'(carry_out), 32'h0);
        tick();
        check("dn1_QE", 32'(Q), 32'hE);
        check("dn1_rcoE", 32'(rco), 32'h0);
        check("dn1_wraps", 32'(wraps), 32'h3);

        // carry_in low blocks counting
        mode     = 2'b00;
        carry_in = 1'b0;
        #1;
        check("cin0_carry_out", 32'(carry_out), 32'h0);
        tick();
        check("cin0_Q", 32'(Q), 32'hE);
        check("cin0_rco", 32'(rco), 32'h0);
        carry_in = 1'b1;

        // Enable toggling in load mode, then async reset mid-cycle
        mode   = 2'b11;
        D      = 4'h3;
        enable = 1'b1;
        tick();
        check("tog_Q3", 32'(Q), 32'h3);
        check("tog_load1", 32'(load), 32'h1);
        enable = 1'b0;
        D      = 4'h9;
        tick();
        check("tog_hold_Q", 32'(Q), 32'h3);
        check("tog_hold_load", 32'(load), 32'h0);
        enable = 1'b1;
        tick();
        check("tog_Q9", 32'(Q), 32'h9);
        enable = 1'b0;
        tick();
        check("tog_hold_Q9", 32'(Q), 32'h9);
        enable = 1'b1;
        D      = 4'h5;
        tick();
        check("tog_Q5", 32'(Q), 32'h5);
        check("tog_match5", 32'(match), 32'h1);
        check("tog_load5", 32'(load), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_Q", 32'(Q), 32'h0);
        check("arst_load", 32'(load), 32'h0);
        check("arst_match", 32'(match), 32'h0);
        check("arst_wraps", 32'(wraps), 32'h0);
        tick();
        reset = 1'b0;

        // Compare match from Q=3 counting up
        mode = 2'b11;
        D    = 4'h3;
        tick();
        check("cmp_Q3_match", 32'(match), 32'h0);
        mode = 2'b00;
        tick();
        check("cmp_Q4_match", 32'(match), 32'h0);
        tick();
        check("cmp_Q5", 32'(Q), 32'h5);
        check("cmp_Q5_match", 32'(match), 32'h1);
        tick();
        check("cmp_Q6_match", 32'(match), 32'h0);

        // Wrap counter saturation: 20 wraps via load F / up
        for (int k = 1; k <= 20; k++) begin
            mode = 2'b11;
            D    = 4'hF;
            tick();
            mode = 2'b00;
            tick();
            check("sat_rco", 32'(rco), 32'h1);
            check("sat_wraps", 32'(wraps), 32'((k < 15) ? k : 15));
        end

        // Two chained stages, 300 edges from reset
        reset_c  = 1'b0;
        chain_en = 1'b1;
        pulses   = 0;
        pulse_at = 0;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (rco_h) begin
                pulses++;
                pulse_at = e;
            end
        end
        chain_en = 1'b0;
        check("chain_value", 32'({qh, ql}), 32'h2C);
        check("chain_hi_pulses", 32'(pulses), 32'd1);
        check("chain_hi_pulse_at", 32'(pulse_at), 32'd256);
        check("chain_hi_wraps", 32'(wr_h), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
